// File: rtl/sprite_layer_scheduler_if.sv
// Position-update handshake between game logic and the sprite layer scheduler.
// The master posts a layer position; the slave answers with a one-cycle ack.
`timescale 1ns/1ps
interface sprite_layer_scheduler_if;
    logic        pos_req;
    logic [1:0]  pos_layer;
    logic [10:0] pos_x_in;
    logic [10:0] pos_y_in;
    logic        pos_ack;

    modport master (
        output pos_req,
        output pos_layer,
        output pos_x_in,
        output pos_y_in,
        input  pos_ack
    );

    modport slave (
        input  pos_req,
        input  pos_layer,
        input  pos_x_in,
        input  pos_y_in,
        output pos_ack
    );
endinterface

// File: rtl/sprite_layer_scheduler.sv
// Per-pixel sprite layer priority mux with tear-free position commit in vblank.
// Define SCHED_COLLISION_EN to add per-frame sprite overlap detection.
`timescale 1ns/1ps
module sprite_layer_scheduler #(
    parameter int         NUM_LAYERS = 4,
    parameter int         H_ACTIVE   = 640,
    parameter int         V_ACTIVE   = 480,
    parameter logic [7:0] BG_COLOR   = 8'h00
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [10:0]              Hcnt,
    input  logic [10:0]              Vcnt,
    input  logic [8*NUM_LAYERS-1:0]  layer_color,
    input  logic [NUM_LAYERS-1:0]    layer_on,
    sprite_layer_scheduler_if.slave  pos,
    output logic [11*NUM_LAYERS-1:0] layer_x,
    output logic [11*NUM_LAYERS-1:0] layer_y,
    output logic [7:0]               pixel_color,
    output logic                     frame_done,
    output logic                     collision
);

    localparam logic [1:0] ACTIVE = 2'd0;
    localparam logic [1:0] COMMIT = 2'd1;
    localparam logic [1:0] VBLANK = 2'd2;

    localparam int              KW     = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
    localparam logic [KW-1:0]   K_LAST = KW'(NUM_LAYERS - 1);
    localparam logic [10:0]     X_MAX  = 11'(H_ACTIVE - 1);
    localparam logic [10:0]     Y_MAX  = 11'(V_ACTIVE - 1);

    logic [1:0]            state;
    logic [KW-1:0]         k;
    logic [10:0]           cur_x [NUM_LAYERS];
    logic [10:0]           cur_y [NUM_LAYERS];
    logic [10:0]           sh_x  [NUM_LAYERS];
    logic [10:0]           sh_y  [NUM_LAYERS];
    logic [NUM_LAYERS-1:0] dirty;

    logic        in_area;
    logic        frame_start;
    logic        frame_end;
    logic        accept;
    logic        layer_ok;
    logic [10:0] x_clamped;
    logic [10:0] y_clamped;
    logic [7:0]  mux_color;

    assign in_area     = (Hcnt < 11'(H_ACTIVE)) && (Vcnt < 11'(V_ACTIVE));
    assign frame_start = (state == ACTIVE) && (Vcnt == 11'(V_ACTIVE))
                         && (Hcnt == 11'd0);
    assign frame_end   = (Vcnt == 11'd0) && (Hcnt == 11'd0);
    assign accept      = pos.pos_req && !pos.pos_ack && (state != COMMIT);
    assign layer_ok    = int'(pos.pos_layer) < NUM_LAYERS;
    assign x_clamped   = (pos.pos_x_in > X_MAX) ? X_MAX : pos.pos_x_in;
    assign y_clamped   = (pos.pos_y_in > Y_MAX) ? Y_MAX : pos.pos_y_in;

    // Walk from lowest priority up so the lowest on index wins.
    always_comb begin
        mux_color = BG_COLOR;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (layer_on[i]) mux_color = layer_color[8*i +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ACTIVE;
            k          <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= frame_start;
            unique case (state)
                ACTIVE: begin
                    if (frame_start) begin
                        state <= COMMIT;
                        k     <= '0;
                    end
                end
                COMMIT: begin
                    if (k == K_LAST) state <= VBLANK;
                    else             k     <= k + 1'b1;
                end
                VBLANK: begin
                    if (frame_end) state <= ACTIVE;
                end
                default: state <= ACTIVE;
            endcase
        end
    end

    // Requests are never accepted in COMMIT, so shadow writes and commits
    // cannot collide on the same dirty bit.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pos.pos_ack <= 1'b0;
            dirty       <= '0;
            for (int i = 0; i < NUM_LAYERS; i++) begin
                cur_x[i] <= '0;
                cur_y[i] <= '0;
                sh_x[i]  <= '0;
                sh_y[i]  <= '0;
            end
        end else begin
            pos.pos_ack <= accept;
            if (accept && layer_ok) begin
                sh_x[pos.pos_layer]  <= x_clamped;
                sh_y[pos.pos_layer]  <= y_clamped;
                dirty[pos.pos_layer] <= 1'b1;
            end
            if (state == COMMIT) begin
                if (dirty[k]) begin
                    cur_x[k] <= sh_x[k];
                    cur_y[k] <= sh_y[k];
                end
                dirty[k] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) pixel_color <= 8'h00;
        else      pixel_color <= in_area ? mux_color : 8'h00;
    end

    for (genvar g = 0; g < NUM_LAYERS; g++) begin : g_pack
        assign layer_x[11*g +: 11] = cur_x[g];
        assign layer_y[11*g +: 11] = cur_y[g];
    end

`ifdef SCHED_COLLISION_EN
    logic overlap;
    logic coll_flag;

    assign overlap = (layer_on & (layer_on - 1'b1)) != '0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            coll_flag <= 1'b0;
            collision <= 1'b0;
        end else if (frame_start) begin
            collision <= coll_flag;
            coll_flag <= 1'b0;
        end else if ((state == ACTIVE) && in_area && overlap) begin
            coll_flag <= 1'b1;
        end
    end
`else
    assign collision = 1'b0;
`endif

endmodule

// File: tb/tb_sprite_layer_scheduler.sv
// Directed plus randomized bench for sprite_layer_scheduler against a
// frame-level reference model (pending-write queue, priority scan).
`timescale 1ns/1ps
module tb_sprite_layer_scheduler;

    localparam int         NL = 4;
    localparam int         HA = 640;
    localparam int         VA = 480;
    localparam logic [7:0] BG = 8'h00;

    typedef struct {
        int          l;
        logic [10:0] x;
        logic [10:0] y;
    } wr_t;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [10:0]       Hcnt;
    logic [10:0]       Vcnt;
    logic [8*NL-1:0]   layer_color;
    logic [NL-1:0]     layer_on;
    logic [11*NL-1:0]  layer_x;
    logic [11*NL-1:0]  layer_y;
    logic [7:0]        pixel_color;
    logic              frame_done;
    logic              collision;

    sprite_layer_scheduler_if pos();

    sprite_layer_scheduler #(
        .NUM_LAYERS (NL),
        .H_ACTIVE   (HA),
        .V_ACTIVE   (VA),
        .BG_COLOR   (BG)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .Hcnt        (Hcnt),
        .Vcnt        (Vcnt),
        .layer_color (layer_color),
        .layer_on    (layer_on),
        .pos         (pos),
        .layer_x     (layer_x),
        .layer_y     (layer_y),
        .pixel_color (pixel_color),
        .frame_done  (frame_done),
        .collision   (collision)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [10:0] cx [NL];
    logic [10:0] cy [NL];
    wr_t         pend [$];
    bit          flag;
    bit          mcoll;
    bit          mact;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11*NL-1:0] packv(input bit sel_y);
        logic [11*NL-1:0] v;
        v = '0;
        for (int i = 0; i < NL; i++) v[11*i +: 11] = sel_y ? cy[i] : cx[i];
        return v;
    endfunction

    function automatic logic [10:0] clampv(input int v, input int m);
        return (v > m) ? 11'(m) : 11'(v);
    endfunction

    // One clock: predict the registered pixel from the current inputs.
    task automatic tick();
        logic [7:0] ep;
        int         n;
        ep = BG;
        n  = 0;
        for (int i = 0; i < NL; i++) begin
            if (layer_on[i]) begin
                if (n == 0) ep = layer_color[8*i +: 8];
                n++;
            end
        end
        if (int'(Hcnt) >= HA || int'(Vcnt) >= VA) ep = 8'h00;
        if (!rst) begin
            ep    = 8'h00;
            flag  = 1'b0;
            mcoll = 1'b0;
        end else if (mact && int'(Hcnt) < HA && int'(Vcnt) < VA && n >= 2) begin
            flag = 1'b1;
        end
        @(posedge clk);
        #1;
        chk("pixel_color", pixel_color, ep);
        chk("collision", collision, mcoll);
    endtask

    task automatic wr(input int l, input int x, input int y);
        wr_t w;
        pos.pos_req   = 1'b1;
        pos.pos_layer = 2'(l);
        pos.pos_x_in  = 11'(x);
        pos.pos_y_in  = 11'(y);
        tick();
        chk("pos_ack", pos.pos_ack, 1);
        pos.pos_req = 1'b0;
        w.l = l;
        w.x = clampv(x, HA - 1);
        w.y = clampv(y, VA - 1);
        pend.push_back(w);
        tick();
        chk("ack_drop", pos.pos_ack, 0);
    endtask

    task automatic frame(input bit stall, input int sl, input int sx,
                         input int sy);
        wr_t w;
        layer_on = '0;
        Vcnt     = 11'(VA);
        Hcnt     = 11'd0;
`ifdef SCHED_COLLISION_EN
        mcoll = flag;
`endif
        flag = 1'b0;
        mact = 1'b0;
        tick();
        chk("frame_done_on", frame_done, 1);
        chk("hold_x", layer_x, packv(1'b0));
        chk("hold_y", layer_y, packv(1'b1));
        Hcnt = 11'd1;
        if (stall) begin
            pos.pos_req   = 1'b1;
            pos.pos_layer = 2'(sl);
            pos.pos_x_in  = 11'(sx);
            pos.pos_y_in  = 11'(sy);
        end
        for (int k = 0; k < NL; k++) begin
            foreach (pend[i]) begin
                if (pend[i].l == k) begin
                    cx[k] = pend[i].x;
                    cy[k] = pend[i].y;
                end
            end
            tick();
            chk("frame_done_off", frame_done, 0);
            chk("commit_x", layer_x, packv(1'b0));
            chk("commit_y", layer_y, packv(1'b1));
            if (stall) chk("stall_ack", pos.pos_ack, 0);
        end
        pend.delete();
        if (stall) begin
            tick();
            chk("vblank_ack", pos.pos_ack, 1);
            pos.pos_req = 1'b0;
            w.l = sl;
            w.x = clampv(sx, HA - 1);
            w.y = clampv(sy, VA - 1);
            pend.push_back(w);
            tick();
            chk("vblank_ack_drop", pos.pos_ack, 0);
        end
        Vcnt = 11'd0;
        Hcnt = 11'd0;
        tick();
        mact = 1'b1;
        Vcnt = 11'd1;
        Hcnt = 11'd1;
    endtask

    initial begin
        bit exp_c;
        Hcnt          = 11'd5;
        Vcnt          = 11'd100;
        layer_on      = '0;
        layer_color   = '0;
        pos.pos_req   = 1'b1;
        pos.pos_layer = 2'd2;
        pos.pos_x_in  = 11'd123;
        pos.pos_y_in  = 11'd45;
        mact  = 1'b1;
        flag  = 1'b0;
        mcoll = 1'b0;
        for (int i = 0; i < NL; i++) begin
            cx[i] = '0;
            cy[i] = '0;
        end

        // Reset held mid-frame with a pending request
        rst = 1'b0;
        repeat (3) begin
            tick();
            chk("rst_ack", pos.pos_ack, 0);
            chk("rst_frame_done", frame_done, 0);
            chk("rst_x", layer_x, 0);
            chk("rst_y", layer_y, 0);
        end
        pos.pos_req = 1'b0;
        rst = 1'b1;
        tick();
        chk("post_rst_ack", pos.pos_ack, 0);
        chk("post_rst_x", layer_x, 0);
        chk("post_rst_y", layer_y, 0);

        // Priority
        Hcnt        = 11'd100;
        Vcnt        = 11'd50;
        layer_color = {8'h33, 8'hE0, 8'h1C, 8'h55};
        layer_on    = 4'b0110;
        tick();
        chk("prio_l1", pixel_color, 8'h1C);
        layer_on = 4'b0000;
        tick();
        chk("prio_bg", pixel_color, BG);
        Hcnt     = 11'd700;
        layer_on = 4'b1111;
        tick();
        chk("prio_blank", pixel_color, 8'h00);
        layer_on = '0;

        // Frame-synchronous update of layer 0
        Hcnt = 11'd20;
        Vcnt = 11'd10;
        wr(0, 200, 300);
        chk("l0_x_pending", layer_x[10:0], 0);
        tick();
        frame(1'b0, 0, 0, 0);
        chk("l0_x_commit", layer_x[10:0], 200);
        chk("l0_y_commit", layer_y[10:0], 300);

        // Stall in COMMIT, clamp on accept
        frame(1'b1, 3, 900, 77);
        chk("l3_x_pending", layer_x[43:33], 0);
        frame(1'b0, 0, 0, 0);
        chk("l3_x_clamped", layer_x[43:33], 639);

        // Overwrite within a frame
        Hcnt = 11'd30;
        Vcnt = 11'd20;
        wr(1, 10, 5);
        wr(1, 20, 600);
        frame(1'b0, 0, 0, 0);
        chk("l1_x_last", layer_x[21:11], 20);
        chk("l1_y_clamp", layer_y[21:11], 479);
        chk("l0_x_kept", layer_x[10:0], 200);

        // Collision on a single overlapping pixel
`ifdef SCHED_COLLISION_EN
        exp_c = 1'b1;
`else
        exp_c = 1'b0;
`endif
        Hcnt     = 11'd40;
        Vcnt     = 11'd30;
        layer_on = 4'b0011;
        tick();
        layer_on = '0;
        tick();
        frame(1'b0, 0, 0, 0);
        chk("coll_set", collision, exp_c);
        Hcnt     = 11'd40;
        Vcnt     = 11'd30;
        layer_on = 4'b0001;
        tick();
        frame(1'b0, 0, 0, 0);
        chk("coll_clear", collision, 0);

        // Randomized frames
        for (int f = 0; f < 8; f++) begin
            int nw;
            nw = int'($urandom_range(4, 0));
            for (int j = 0; j < 10; j++) begin
                Hcnt        = 11'($urandom_range(799, 0));
                Vcnt        = 11'($urandom_range(524, 0));
                if (Vcnt == 11'(VA) && Hcnt == 11'd0) Hcnt = 11'd1;
                layer_on    = NL'($urandom);
                layer_color = (8*NL)'($urandom);
                tick();
            end
            for (int j = 0; j < nw; j++) begin
                Hcnt     = 11'($urandom_range(799, 1));
                Vcnt     = 11'($urandom_range(470, 1));
                layer_on = NL'($urandom);
                wr(int'($urandom_range(NL - 1, 0)),
                   int'($urandom_range(1023, 0)),
                   int'($urandom_range(1023, 0)));
            end
            frame(bit'($urandom_range(1, 0)),
                  int'($urandom_range(NL - 1, 0)),
                  int'($urandom_range(1023, 0)),
                  int'($urandom_range(1023, 0)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sprite_layer_scheduler.md
Name: sprite_layer_scheduler

Overview:
Arbitrates the VGA pixel output among NUM_LAYERS sprite display units (player 1, player 2, ball, score). Each unit supplies a registered 8-bit colour and a displayed flag. The block resolves layer priority per pixel and owns every layer's x/y position. Game logic posts position updates through a req/ack handshake; the block holds them in shadow registers and commits them only during vertical blanking, so no sprite tears mid-frame.

Parameters:
NUM_LAYERS, 4, number of sprite layers; index 0 = highest priority
H_ACTIVE, 640, visible pixels per line
V_ACTIVE, 480, visible lines per frame
BG_COLOR, 8'h00, colour driven when no layer is displayed in the active area

Ports:
clk  input  1  pixel clock
rst  input  1  synchronous reset, active-low (asserted when 0, sampled on posedge clk)
Hcnt  input  11  current horizontal pixel count
Vcnt  input  11  current vertical line count
layer_color  input  8*NUM_LAYERS  per-layer colour; layer i at bits [8i+7:8i]
layer_on  input  NUM_LAYERS  per-layer displayed flag
pos_req  input  1  position update request
pos_layer  input  2  target layer index for the update
pos_x_in  input  11  requested x
pos_y_in  input  11  requested y
pos_ack  output  1  one-cycle acceptance pulse
layer_x  output  11*NUM_LAYERS  committed x per layer; feeds the display units
layer_y  output  11*NUM_LAYERS  committed y per layer
pixel_color  output  8  composited colour to the VGA output
frame_done  output  1  one-cycle pulse on commit entry
collision  output  1  two or more layers overlapped in the last frame

Behaviour:
- Reset (rst==0 at posedge): pixel_color=0, pos_ack=0, frame_done=0, collision=0. All layer_x/layer_y and shadow registers =0, all shadow-dirty bits =0, state=ACTIVE, commit counter=0. A pending request is dropped without ack; the requester re-asserts it.
- FSM states: ACTIVE, COMMIT, VBLANK.
  - ACTIVE -> COMMIT when Vcnt==V_ACTIVE and Hcnt==0.
  - COMMIT lasts exactly NUM_LAYERS cycles. Commit counter k goes 0..NUM_LAYERS-1. In cycle k, layer k's shadow copies to layer_x/layer_y if dirty[k]=1, then dirty[k] clears. COMMIT -> VBLANK after k=NUM_LAYERS-1.
  - VBLANK -> ACTIVE when Vcnt==0 and Hcnt==0.
- Compositing: pixel_color is registered, 1 cycle after layer_color/layer_on.
  - If Hcnt>=H_ACTIVE or Vcnt>=V_ACTIVE, output 0.
  - Otherwise the lowest-index layer with layer_on=1 wins.
  - If no layer is on, output BG_COLOR.
- Handshake:
  - pos_req is sampled only when pos_ack=0 and state!=COMMIT.
  - pos_ack pulses high the cycle after acceptance. Accepted values write shadow[pos_layer] and set dirty[pos_layer].
  - During COMMIT the request stalls: no ack, and it is accepted on the first VBLANK cycle.
  - pos_req high during the ack cycle is ignored; the requester deasserts it after ack.
  - pos_layer>=NUM_LAYERS: acked, no write.
- Clamping: pos_x_in>H_ACTIVE-1 stores H_ACTIVE-1; pos_y_in>V_ACTIVE-1 stores V_ACTIVE-1.
- Repeated writes to one layer within a frame: the last accepted write wins.
- A write accepted in VBLANK commits at the next frame's COMMIT.
- frame_done pulses for 1 cycle on the first COMMIT cycle.

Optional Feature:
SCHED_COLLISION_EN. Defined:
- A sticky internal flag sets when 2 or more layer_on bits are high in the active area during ACTIVE.
- On COMMIT entry the flag copies to collision and the internal flag clears.
- collision holds until the next COMMIT entry.

Undefined: collision is tied to 0 and the detection logic is absent.

Test Plan:
- Reset: hold rst=0 for 3 cycles mid-frame with pos_req=1 -> all outputs 0, no pos_ack, layer_x/y all 0 after release.
- Priority: Hcnt=100, Vcnt=50, layer_on=4'b0110, layer1 colour=8'h1C, layer2 colour=8'hE0 -> pixel_color=8'h1C one cycle later. layer_on=0 -> BG_COLOR. Hcnt=700 -> 0.
- Frame-sync update: request layer 0 to x=200, y=300 at Vcnt=10 -> pos_ack 1 cycle later; layer_x[0] stays 0 until Vcnt=480, Hcnt=0; reads 200/300 after commit cycle 0; frame_done pulses once.
- Stall/clamp: assert pos_req (layer 3, x=900) on the first COMMIT cycle -> no ack until the first VBLANK cycle; the next frame commits x=639.
- Overwrite: two accepted writes to layer 1 (x=10 then x=20) in one frame -> commit yields 20; layers without writes keep their old values.
- Collision (SCHED_COLLISION_EN): layer_on=4'b0011 for 1 pixel in the active area -> collision=1 at frame_done. Next frame with no overlap -> collision=0. Without the macro, collision stays 0.
